fxp_round_arb: RTL and testbench

FXP_ROUND_ARB -- requirements
Module: fxp_round_arb

---
 rtl/fxp_round_arb.sv | 189 ++++++++++++++++++
 tb/tb_fxp_round_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_round_arb.sv
// -----------------------------------------------------------------------------
// fxp_round_arb
//
// Two-requester round-robin front end for a shared fixed-point rounding unit.
// One request is granted per cycle at most. The granted payload (vxrm mode, the
// per-lane rounding bits and the unrounded vector) is steered combinationally
// onto the ru_* bus. The rounding unit's combinational sum (ru_vec_out) is
// captured into the output register on the next rising edge. Latency is one
// cycle, and the design sustains one result per cycle while out_ready is high.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   req_valid    [1:0]              request valid, bit i = requester i
//   req_ready    [1:0]              one-hot grant (request accepted this cycle)
//   req_vxrm     [3:0]              rounding mode, bits [2i+1:2i] = requester i
//   req_vec      [2*DATA_WIDTH-1:0] unrounded vector, slice i = requester i
//   req_d        [2*DW_B-1:0]       per-lane v[d] bit, slice i = requester i
//   req_d1       [2*DW_B-1:0]       per-lane v[d-1] bit
//   req_d10      [2*DW_B-1:0]       per-lane sticky bit of v[d-2:0]
//   ru_vxrm      [1:0]              mode to the rounding unit
//   ru_v_d/_d1/_d10 [DW_B-1:0]      lane bits to the rounding unit
//   ru_vec_in    [DATA_WIDTH-1:0]   vector to the rounding unit
//   ru_in_valid                     rounding-unit operand valid
//   ru_vec_out   [DATA_WIDTH-1:0]   combinational result from the rounding unit
//   out_valid                       result held in the output register
//   out_ready                       downstream accepts the result
//   out_vec      [DATA_WIDTH-1:0]   registered rounded result
//   out_id                          requester that produced out_vec
// -----------------------------------------------------------------------------
module fxp_round_arb #(
   parameter int DATA_WIDTH = 64,
   parameter int DW_B       = DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [3:0]                req_vxrm,
   input  logic [2*DATA_WIDTH-1:0]   req_vec,
   input  logic [2*DW_B-1:0]         req_d,
   input  logic [2*DW_B-1:0]         req_d1,
   input  logic [2*DW_B-1:0]         req_d10,
   output logic [1:0]                ru_vxrm,
   output logic [DW_B-1:0]           ru_v_d,
   output logic [DW_B-1:0]           ru_v_d1,
   output logic [DW_B-1:0]           ru_v_d10,
   output logic [DATA_WIDTH-1:0]     ru_vec_in,
   output logic                      ru_in_valid,
   input  logic [DATA_WIDTH-1:0]     ru_vec_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_vec,
   output logic                      out_id
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0]   out_vec_q;
   logic                    out_id_q;

   logic                    can_accept;
   logic [1:0]              gnt;
   logic                    gnt_any;
   logic                    gnt_idx;

   // Per-requester views of the packed request buses.
   logic [1:0]              vxrm_a [2];
   logic [DATA_WIDTH-1:0]   vec_a  [2];
   logic [DW_B-1:0]         d_a    [2];
   logic [DW_B-1:0]         d1_a   [2];
   logic [DW_B-1:0]         d10_a  [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign vxrm_a[gi] = req_vxrm[2*gi +: 2];
         assign vec_a[gi]  = req_vec[gi*DATA_WIDTH +: DATA_WIDTH];
         assign d_a[gi]    = req_d[gi*DW_B +: DW_B];
         assign d1_a[gi]   = req_d1[gi*DW_B +: DW_B];
         assign d10_a[gi]  = req_d10[gi*DW_B +: DW_B];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   assign can_accept = (state_q == EMPTY) | out_ready;

   // rst gates the grant so that no request is accepted and nothing is
   // presented to the rounding unit while reset is held, even between edges.
   always_comb begin
      gnt = 2'b00;
      if (rst && can_accept) begin
         if (req_valid == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
         end else begin
            gnt = req_valid;
         end
      end
   end

   assign gnt_any = |gnt;
   assign gnt_idx = gnt[1];

   // After a grant the other requester becomes favoured. This gives strict
   // alternation when both requesters are valid back to back.
   assign ptr_d = gnt_any ? ~gnt_idx : ptr_q;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (gnt_any) state_d = FULL;
         end
         FULL: begin
            if (gnt_any) begin
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and rounding-unit steering
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid   = (state_q == FULL);
      req_ready   = gnt;
      ru_in_valid = 1'b0;
      ru_vxrm     = '0;
      ru_v_d      = '0;
      ru_v_d1     = '0;
      ru_v_d10    = '0;
      ru_vec_in   = '0;
      if (gnt_any) begin
         ru_in_valid = 1'b1;
         ru_vxrm     = vxrm_a[gnt_idx];
         ru_v_d      = d_a[gnt_idx];
         ru_v_d1     = d1_a[gnt_idx];
         ru_v_d10    = d10_a[gnt_idx];
         ru_vec_in   = vec_a[gnt_idx];
      end
   end

   // ---------------------------------------------------------------------------
   // Result register and priority pointer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vec_q <= '0;
         out_id_q  <= 1'b0;
         ptr_q     <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         // The result is kept after the downstream takes it. Only a new grant
         // overwrites it.
         if (gnt_any) begin
            out_vec_q <= ru_vec_out;
            out_id_q  <= gnt_idx;
         end
      end
   end

   assign out_vec = out_vec_q;
   assign out_id  = out_id_q;

endmodule

// File: tb/tb_fxp_round_arb.sv
// -----------------------------------------------------------------------------
// tb_fxp_round_arb
//
// Directed bench for fxp_round_arb. A behavioural fixed-point rounding unit
// (RNU / RNE / RDN / ROD, per byte lane, with no carry between lanes) closes
// the ru_* loop. Expected values are worked out by hand in the steps below.
// -----------------------------------------------------------------------------
module tb_fxp_round_arb;

   localparam int DW  = 64;
   localparam int DWB = DW / 8;

   logic              clk;
   logic              rst;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [3:0]        req_vxrm;
   logic [2*DW-1:0]   req_vec;
   logic [2*DWB-1:0]  req_d;
   logic [2*DWB-1:0]  req_d1;
   logic [2*DWB-1:0]  req_d10;
   logic [1:0]        ru_vxrm;
   logic [DWB-1:0]    ru_v_d;
   logic [DWB-1:0]    ru_v_d1;
   logic [DWB-1:0]    ru_v_d10;
   logic [DW-1:0]     ru_vec_in;
   logic              ru_in_valid;
   logic [DW-1:0]     ru_vec_out;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_vec;
   logic              out_id;

   int checks;
   int failures;

   fxp_round_arb #(.DATA_WIDTH(DW), .DW_B(DWB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_vxrm   (req_vxrm),
      .req_vec    (req_vec),
      .req_d      (req_d),
      .req_d1     (req_d1),
      .req_d10    (req_d10),
      .ru_vxrm    (ru_vxrm),
      .ru_v_d     (ru_v_d),
      .ru_v_d1    (ru_v_d1),
      .ru_v_d10   (ru_v_d10),
      .ru_vec_in  (ru_vec_in),
      .ru_in_valid(ru_in_valid),
      .ru_vec_out (ru_vec_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_vec    (out_vec),
      .out_id     (out_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rounding increment for one lane, following the RISC-V vxrm definitions.
   function automatic logic rnd_inc(input logic [1:0] mode, input logic d,
                                    input logic d1, input logic d10);
      case (mode)
         2'b00:   return d1;               // RNU
         2'b01:   return d1 & (d10 | d);   // RNE
         2'b10:   return 1'b0;             // RDN
         default: return ~d & (d1 | d10);  // ROD
      endcase
   endfunction

   always_comb begin
      ru_vec_out = '0;
      for (int l = 0; l < DWB; l++) begin
         ru_vec_out[8*l +: 8] = ru_vec_in[8*l +: 8]
                              + {7'd0, rnd_inc(ru_vxrm, ru_v_d[l], ru_v_d1[l], ru_v_d10[l])};
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clr_req();
      req_valid = 2'b00;
      req_vxrm  = '0;
      req_vec   = '0;
      req_d     = '0;
      req_d1    = '0;
      req_d10   = '0;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      out_ready = 1'b1;
      clr_req();
      req_valid = 2'b11;   // requests must be ignored while reset is held

      // ---- reset state ----
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_vec", 128'(out_vec), 128'(64'h0));
      chk("rst_out_id", 128'(out_id), 128'(1'b0));
      chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
      chk("rst_ru_valid", 128'(ru_in_valid), 128'(1'b0));
      to_pos();
      to_pos();
      chk("rst_hold_valid", 128'(out_valid), 128'(1'b0));
      clr_req();
      rst = 1'b1;

      // ---- req0 RNU: 0x10 with d1 lane0 -> 0x11 ----
      req_valid = 2'b01;
      req_vxrm  = 4'b0000;
      req_vec[63:0] = 64'h10;
      req_d1[7:0]   = 8'h01;
      to_neg();
      chk("rnu_ready", 128'(req_ready), 128'(2'b01));
      chk("rnu_ru_valid", 128'(ru_in_valid), 128'(1'b1));
      chk("rnu_ru_vec", 128'(ru_vec_in), 128'(64'h10));
      to_pos();
      chk("rnu_out_valid", 128'(out_valid), 128'(1'b1));
      chk("rnu_out_vec", 128'(out_vec), 128'(64'h11));
      chk("rnu_out_id", 128'(out_id), 128'(1'b0));

      // ---- drain: FULL -> EMPTY, result register keeps its value ----
      clr_req();
      to_neg();
      chk("idle_ready", 128'(req_ready), 128'(2'b00));
      chk("idle_ru_valid", 128'(ru_in_valid), 128'(1'b0));
      chk("idle_ru_vec", 128'(ru_vec_in), 128'(64'h0));
      to_pos();
      chk("drain_valid", 128'(out_valid), 128'(1'b0));
      chk("drain_vec", 128'(out_vec), 128'(64'h11));

      // ---- req0 ROD: 0x20, d=0, d10 lane0 -> 0x21 (pointer stays at 1) ----
      req_valid = 2'b01;
      req_vxrm  = 4'b0011;
      req_vec[63:0] = 64'h20;
      req_d10[7:0]  = 8'h01;
      to_neg();
      chk("rod_ru_vxrm", 128'(ru_vxrm), 128'(2'b11));
      to_pos();
      chk("rod_out_vec", 128'(out_vec), 128'(64'h21));
      chk("rod_out_id", 128'(out_id), 128'(1'b0));

      // ---- req1 RDN: d1 all ones, result truncated (back to back) ----
      clr_req();
      req_valid = 2'b10;
      req_vxrm  = 4'b1000;
      req_vec[127:64] = 64'h0123456789ABCDEF;
      req_d1[15:8]    = 8'hFF;
      to_neg();
      chk("rdn_ready", 128'(req_ready), 128'(2'b10));
      chk("rdn_ru_vxrm", 128'(ru_vxrm), 128'(2'b10));
      chk("rdn_ru_d1", 128'(ru_v_d1), 128'(8'hFF));
      to_pos();
      chk("rdn_out_vec", 128'(out_vec), 128'(64'h0123456789ABCDEF));
      chk("rdn_out_id", 128'(out_id), 128'(1'b1));
      chk("rdn_out_valid", 128'(out_valid), 128'(1'b1));

      // ---- both valid: alternate 0,1,0,1 ----
      // req0: RNU, 0xA0, no round bits -> 0xA0
      // req1: RNE, 0x12FF, d=d1=1 in lane0 -> lane0 wraps to 0x00, no carry -> 0x1200
      clr_req();
      req_valid = 2'b11;
      req_vxrm  = 4'b0100;
      req_vec[63:0]   = 64'hA0;
      req_vec[127:64] = 64'h12FF;
      req_d[15:8]     = 8'h01;
      req_d1[15:8]    = 8'h01;
      for (int k = 0; k < 4; k++) begin
         to_neg();
         chk($sformatf("rr%0d_ready", k), 128'(req_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
         to_pos();
         chk($sformatf("rr%0d_out_id", k), 128'(out_id), 128'(k % 2));
         chk($sformatf("rr%0d_out_vec", k), 128'(out_vec), (k % 2 == 0) ? 128'(64'hA0) : 128'(64'h1200));
      end

      // ---- backpressure: 3 cycles with out_ready=0, both valid ----
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         to_neg();
         chk($sformatf("bp%0d_ready", k), 128'(req_ready), 128'(2'b00));
         chk($sformatf("bp%0d_ru_valid", k), 128'(ru_in_valid), 128'(1'b0));
         to_pos();
         chk($sformatf("bp%0d_out_vec", k), 128'(out_vec), 128'(64'h1200));
         chk($sformatf("bp%0d_out_id", k), 128'(out_id), 128'(1'b1));
         chk($sformatf("bp%0d_valid", k), 128'(out_valid), 128'(1'b1));
      end
      out_ready = 1'b1;
      to_neg();
      chk("bp_rel_ready", 128'(req_ready), 128'(2'b01));
      to_pos();
      chk("bp_rel_out_id", 128'(out_id), 128'(1'b0));
      chk("bp_rel_out_vec", 128'(out_vec), 128'(64'hA0));

      // ---- async reset mid-transfer (pointer currently favours req1) ----
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(1'b0));
      chk("arst_vec", 128'(out_vec), 128'(64'h0));
      chk("arst_ready", 128'(req_ready), 128'(2'b00));
      chk("arst_ru_valid", 128'(ru_in_valid), 128'(1'b0));
      to_pos();
      chk("arst_hold", 128'(out_valid), 128'(1'b0));
      rst = 1'b1;
      to_neg();
      chk("arst_rel_ready", 128'(req_ready), 128'(2'b01));
      to_pos();
      chk("arst_rel_id", 128'(out_id), 128'(1'b0));
      chk("arst_rel_valid", 128'(out_valid), 128'(1'b1));

      clr_req();
      to_pos();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stalled simulation.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
